// File: rtl/scb_mul_param.sv
// rtl/scb_mul_param.sv - streaming negacyclic schoolbook multiplier, acc mod 2^Q_BITS
// The secret rotates one slot per public accept; a final sign flip restores it after N rotations.
module scb_mul_param #(
  parameter int N      = 256,
  parameter int Q_BITS = 13,
  parameter int S_BITS = 4,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_acc,
  input  logic              reuse_secret,
  input  logic              s_valid,
  input  logic [S_BITS-1:0] s_data,
  output logic              s_ready,
  input  logic              a_valid,
  input  logic [Q_BITS-1:0] a_data,
  output logic              a_ready,
  output logic              busy,
  output logic              done,
  output logic              secret_held,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [Q_BITS-1:0] rd_data
);
  localparam int P_BITS = Q_BITS + S_BITS - 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_MAC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [S_BITS-1:0] SIGN_BIT = {1'b1, {(S_BITS-1){1'b0}}};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [S_BITS-1:0] r_sec [N];
  logic [Q_BITS-1:0] r_acc [N];
  logic              r_held;
  logic [Q_BITS-1:0] r_rd_data;

  logic              w_last;
  logic [P_BITS-1:0] w_prod    [N];
  logic [Q_BITS-1:0] w_acc_mac [N];
  logic [S_BITS-1:0] w_sec_rot [N];

  assign w_last      = (r_cnt == LAST_IDX);
  assign s_ready     = (r_state == ST_LOAD);
  assign a_ready     = (r_state == ST_MAC);
  assign busy        = (r_state == ST_LOAD) || (r_state == ST_MAC);
  assign done        = (r_state == ST_DONE);
  assign secret_held = r_held;
  assign rd_data     = r_rd_data;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_prod[i] = P_BITS'(a_data) * P_BITS'(r_sec[i][S_BITS-2:0]);
      if (r_sec[i][S_BITS-1])
        w_acc_mac[i] = r_acc[i] - w_prod[i][Q_BITS-1:0];
      else
        w_acc_mac[i] = r_acc[i] + w_prod[i][Q_BITS-1:0];
    end
  end

  // Multiplying by x: wrap-around coefficient picks up a sign change (x^N = -1)
  always_comb begin
    w_sec_rot[0] = r_sec[N-1] ^ SIGN_BIT;
    for (int i = 1; i < N; i++) w_sec_rot[i] = r_sec[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_held    <= 1'b0;
      r_rd_data <= '0;
      for (int i = 0; i < N; i++) begin
        r_sec[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      r_rd_data <= r_acc[rd_addr];
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_cnt <= '0;
            if (clear_acc)
              for (int i = 0; i < N; i++) r_acc[i] <= '0;
            if (reuse_secret && r_held) begin
              r_state <= ST_MAC;
            end else begin
              r_state <= ST_LOAD;
              r_held  <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            for (int i = 0; i < N - 1; i++) r_sec[i] <= r_sec[i+1];
            r_sec[N-1] <= s_data;
            r_cnt      <= r_cnt + ADDR_W'(1);
            if (w_last) begin
              r_held  <= 1'b1;
              r_state <= ST_MAC;
            end
          end
        end
        ST_MAC: begin
          if (a_valid) begin
            for (int i = 0; i < N; i++) begin
              r_acc[i] <= w_acc_mac[i];
              r_sec[i] <= w_last ? (w_sec_rot[i] ^ SIGN_BIT) : w_sec_rot[i];
            end
            r_cnt <= r_cnt + ADDR_W'(1);
            if (w_last) r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scb_mul_param.sv
// tb/tb_scb_mul_param.sv - directed and randomized bench for scb_mul_param
// Drives an N=4 and an N=256 instance from shared stimulus against a convolution model.
module tb_scb_mul_param;
  logic        clk;
  logic        rst;
  logic        start4, start_b;
  logic        clear_acc, reuse_secret, s_valid, a_valid;
  logic [3:0]  s_data;
  logic [12:0] a_data;
  logic [7:0]  rd_addr;
  logic        s_ready4, a_ready4, busy4, done4, held4;
  logic        s_ready_b, a_ready_b, busy_b, done_b, held_b;
  logic [12:0] rd_data4, rd_data_b;

  int checks = 0;
  int errors = 0;
  int sv[256];
  int av[256];
  int exp_acc[2][256];
  int busy_cyc, stall_cyc;
  bit saw_sready;
  logic [12:0] got;

  scb_mul_param #(.N(4), .Q_BITS(13), .S_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .clear_acc(clear_acc), .reuse_secret(reuse_secret),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready4),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .busy(busy4), .done(done4), .secret_held(held4),
    .rd_addr(rd_addr[1:0]), .rd_data(rd_data4)
  );

  scb_mul_param #(.N(256), .Q_BITS(13), .S_BITS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear_acc(clear_acc), .reuse_secret(reuse_secret),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_b),
    .busy(busy_b), .done(done_b), .secret_held(held_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Golden negacyclic product: x^k for k >= n folds back with a minus sign
  task automatic model_mul(input bit big, input int n, input bit clr);
    int sval, term, k;
    if (clr) for (int i = 0; i < 256; i++) exp_acc[big][i] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        sval = sv[j] % 8;
        if (sv[j] >= 8) sval = -sval;
        term = av[i] * sval;
        k = i + j;
        if (k < n) exp_acc[big][k] += term;
        else       exp_acc[big][k-n] -= term;
      end
    end
    for (int i = 0; i < n; i++) exp_acc[big][i] = exp_acc[big][i] & 8191;
  endtask

  task automatic read_one(input bit big, input int addr, output logic [12:0] val);
    rd_addr = 8'(addr);
    @(posedge clk); #1;
    val = big ? rd_data_b : rd_data4;
  endtask

  task automatic read_check(input bit big, input int n, input string tag);
    logic [12:0] v;
    for (int k = 0; k < n; k++) begin
      read_one(big, k, v);
      chk($sformatf("%s_acc%0d", tag, k), 32'(v), 32'(exp_acc[big][k] & 8191));
    end
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) start_b = v; else start4 = v;
  endtask

  task automatic run(input bit big, input int n, input bit clr, input bit reuse, input bit gaps,
                     input int poke_at, input int abort_at, input string tag);
    int si, ai, cyc;
    bit fin, ab, sr, ar, bz, s_acc, a_acc;
    si = 0; ai = 0; cyc = 0; fin = 0; ab = 0;
    busy_cyc = 0; stall_cyc = 0; saw_sready = 0;
    clear_acc = clr; reuse_secret = reuse;
    set_start(big, 1'b1);
    @(posedge clk); #1;
    set_start(big, 1'b0);
    clear_acc = 0; reuse_secret = 0;
    while (!fin && !ab && cyc < 6000) begin
      sr = big ? s_ready_b : s_ready4;
      ar = big ? a_ready_b : a_ready4;
      bz = big ? busy_b : busy4;
      if (sr) saw_sready = 1;
      s_acc = sr && si < n && (!gaps || $urandom_range(0, 3) != 0);
      a_acc = ar && ai < n && (!gaps || $urandom_range(0, 3) != 0);
      s_valid = s_acc || (!sr && $urandom_range(0, 1) == 1);
      s_data  = s_acc ? 4'(sv[si]) : 4'($urandom_range(0, 15));
      a_valid = a_acc || (!ar && $urandom_range(0, 1) == 1);
      a_data  = a_acc ? 13'(av[ai]) : 13'($urandom_range(0, 8191));
      set_start(big, (poke_at >= 0 && sr && si == poke_at) ? 1'b1 : 1'b0);
      if (bz) begin
        busy_cyc++;
        if (!s_acc && !a_acc) stall_cyc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (s_acc) si++;
      if (a_acc) ai++;
      if (abort_at >= 0 && ai == abort_at) ab = 1;
      if (ai == n) fin = 1;
    end
    s_valid = 0; a_valid = 0;
    set_start(big, 1'b0);
    if (!ab) begin
      chk({tag, "_done"}, 32'(big ? done_b : done4), 32'd1);
      chk({tag, "_busy_low"}, 32'(big ? busy_b : busy4), 32'd0);
    end
  endtask

  initial begin
    rst = 1; start4 = 0; start_b = 0; clear_acc = 0; reuse_secret = 0;
    s_valid = 0; a_valid = 0; s_data = 0; a_data = 0; rd_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",   32'({done4, done_b}), 32'd0);
    chk("rst_busy",   32'({busy4, busy_b}), 32'd0);
    chk("rst_held",   32'({held4, held_b}), 32'd0);
    chk("rst_ready",  32'({s_ready4, a_ready4, s_ready_b, a_ready_b}), 32'd0);
    chk("rst_rd4",    32'(rd_data4), 32'd0);
    chk("rst_rd_b",   32'(rd_data_b), 32'd0);
    rst = 0;

    // identity secret
    sv[0] = 1; sv[1] = 0; sv[2] = 0; sv[3] = 0;
    av[0] = 5; av[1] = 6; av[2] = 7; av[3] = 8;
    run(0, 4, 1, 0, 0, -1, -1, "t1");
    chk("t1_held", 32'(held4), 32'd1);
    model_mul(0, 4, 1);
    read_check(0, 4, "t1");

    // secret = x; then reuse to confirm the secret came back unchanged
    sv[0] = 0; sv[1] = 1;
    run(0, 4, 1, 0, 0, -1, -1, "t2");
    model_mul(0, 4, 1);
    read_check(0, 4, "t2");
    read_one(0, 0, got);
    chk("t2_wrap", 32'(got), 32'd8184);
    run(0, 4, 0, 1, 0, -1, -1, "t2r");
    chk("t2r_no_sready", 32'(saw_sready), 32'd0);
    chk("t2r_cycles", busy_cyc, 4);
    model_mul(0, 4, 0);
    read_check(0, 4, "t2r");

    // negative secret coefficient, then accumulate with reuse
    sv[0] = 11; sv[1] = 0;
    av[0] = 2; av[1] = 0; av[2] = 0; av[3] = 0;
    run(0, 4, 1, 0, 0, -1, -1, "t3");
    read_one(0, 0, got);
    chk("t3_acc0", 32'(got), 32'd8186);
    run(0, 4, 0, 1, 0, -1, -1, "t3r");
    chk("t3r_no_sready", 32'(saw_sready), 32'd0);
    read_one(0, 0, got);
    chk("t3r_acc0", 32'(got), 32'd8180);
    model_mul(0, 4, 1);
    model_mul(0, 4, 0);
    read_check(0, 4, "t3r");

    // full-size random with gaps and a stray start during load
    for (int i = 0; i < 256; i++) begin
      sv[i] = $urandom_range(0, 15);
      av[i] = $urandom_range(0, 8191);
    end
    run(1, 256, 1, 0, 1, 40, -1, "r1");
    chk("r1_cycles", busy_cyc, 512 + stall_cyc);
    model_mul(1, 256, 1);
    read_check(1, 256, "r1");

    for (int i = 0; i < 256; i++) av[i] = $urandom_range(0, 8191);
    run(1, 256, 0, 1, 1, -1, -1, "r2");
    chk("r2_cycles", busy_cyc, 256 + stall_cyc);
    model_mul(1, 256, 0);
    read_check(1, 256, "r2");

    // reset after 100 public accepts
    for (int i = 0; i < 256; i++) av[i] = $urandom_range(0, 8191);
    run(1, 256, 1, 1, 1, -1, 100, "ab");
    rst = 1;
    #1;
    chk("ab_busy",  32'(busy_b), 32'd0);
    chk("ab_done",  32'(done_b), 32'd0);
    chk("ab_ready", 32'({s_ready_b, a_ready_b}), 32'd0);
    chk("ab_held",  32'({held_b, held4}), 32'd0);
    chk("ab_rd",    32'(rd_data_b), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    run(1, 256, 0, 1, 1, -1, -1, "r3");
    chk("r3_sready", 32'(saw_sready), 32'd1);
    chk("r3_cycles", busy_cyc, 512 + stall_cyc);
    for (int i = 0; i < 256; i++) exp_acc[1][i] = 0;
    model_mul(1, 256, 0);
    read_check(1, 256, "r3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scb_mul_param.md
Name: scb_mul_param

Overview:
- Parametrised, streaming schoolbook negacyclic polynomial multiplier: result = a(x)·s(x) mod (x^N+1), coefficients mod 2^Q_BITS.
- Next generation of the fixed 256×13-bit parallel-MAC multiplier. Adds:
  - generic N, Q_BITS and S_BITS;
  - valid/ready streaming for secret and public operands;
  - secret retention with automatic sign restore;
  - accumulate-onto-previous mode, for matrix-vector inner products;
  - an addressed result read port.

Parameters:
- N, 256, polynomial length; power of two, ≥4.
- Q_BITS, 13, public/accumulator coefficient width; arithmetic is mod 2^Q_BITS.
- S_BITS, 4, secret coefficient width, sign-magnitude: MSB = sign, low S_BITS-1 bits = magnitude.
- ADDR_W, $clog2(N), read-address and counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled in IDLE and DONE only.
- clear_acc  in  1  sampled with start: 1 = zero accumulators, 0 = accumulate onto current contents.
- reuse_secret  in  1  sampled with start: 1 = skip secret load if a secret is held.
- s_valid  in  1  secret coefficient valid.
- s_data  in  S_BITS  secret coefficient, index 0 first.
- s_ready  out  1  high in LOAD_S.
- a_valid  in  1  public coefficient valid.
- a_data  in  Q_BITS  public coefficient, index 0 first.
- a_ready  out  1  high in MAC.
- busy  out  1  high in LOAD_S or MAC.
- done  out  1  high in DONE; held until next accepted start.
- secret_held  out  1  a complete secret is stored.
- rd_addr  in  ADDR_W  result coefficient index.
- rd_data  out  Q_BITS  acc[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset (async): state=IDLE; all acc, secret, counters = 0; s_ready=a_ready=busy=done=secret_held=rd_data=0. Reset mid-LOAD_S/MAC aborts the operation and secret_held clears.
- Storage: secret register holds N×S_BITS bits, coefficient i at [i*S_BITS +: S_BITS]; acc holds N×Q_BITS bits.
- IDLE/DONE, on start:
  - done←0;
  - if clear_acc, all acc←0 in the same edge;
  - next state = MAC if (reuse_secret && secret_held), else LOAD_S.
- LOAD_S:
  - s_ready=1; each s_valid&&s_ready shifts the secret right by one coefficient, inserting s_data at the top (index N-1), so the first accepted coefficient lands at index 0 after N accepts.
  - Count 0..N-1; on the Nth accept: secret_held←1, go MAC. No bubbles are required; s_valid gaps stall.
- MAC:
  - a_ready=1; on each a_valid&&a_ready, for every i in parallel: acc[i] ← (acc[i] + (sign_i ? -(a·mag_i) : a·mag_i)) mod 2^Q_BITS.
  - Same edge: negacyclic rotate: s[i]←s[i-1] for i≥1; s[0]←s[N-1] with its sign bit inverted.
  - Product width Q_BITS+S_BITS-1, truncated to Q_BITS. Magnitude 0 contributes 0 regardless of sign.
  - On the Nth accept: invert the sign bit of every secret coefficient in the same edge, so the stored secret equals the originally loaded bits (N rotations give -s). Then go DONE.
- DONE: done=1; acc stable; start behaves as in IDLE.
- start while busy is ignored; no queuing.
- rd port is usable in any state; during MAC it returns in-progress values. rd_data is updated every cycle from rd_addr.
- Backpressure: a_valid low for any number of cycles holds all state; counters do not advance.
- s_valid in MAC and a_valid in LOAD_S are ignored; their ready signals are low.
- Throughput: N+N cycles for load plus compute; N cycles with reuse_secret.

Test Plan:
- N=4, Q=13: s=[1,0,0,0], a=[5,6,7,8], clear_acc=1 → rd 0..3 = 5,6,7,8; done=1 one cycle after the 4th a accept.
- N=4: s=[0,1,0,0] (x), a=[5,6,7,8] → acc=[8184,5,6,7]; after done, secret bits read back equal to loaded (sign restore).
- N=4: s=[0b1011 (-3),0,0,0], a=[2,0,0,0] → acc0=8186, others 0; then start with reuse_secret=1, clear_acc=0, same a → acc0=8180, with no s_ready assertion.
- Default N=256, random s, a, with random a_valid/s_valid gaps → matches golden negacyclic model mod 8192; cycle count = 512 + stall cycles.
- rst pulse mid-MAC (after 100 accepts) → all outputs 0 immediately, secret_held=0; next start with reuse_secret=1 enters LOAD_S.
- start pulsed during LOAD_S → ignored; operation completes unchanged.
